// File: rtl/alu_result_display_if.sv
// Result/display bus between the ALU output and the seven-segment display driver.
// master = ALU side (drives result); slave = display driver.
interface alu_result_display_if;
    logic [7:0] result;
    logic       busy;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output result,
        input  busy, bcd_hundreds, bcd_tens, bcd_ones, an, seg, dp
    );

    modport slave (
        input  result,
        output busy, bcd_hundreds, bcd_tens, bcd_ones, an, seg, dp
    );
endinterface

// File: rtl/alu_result_display.sv
// Converts the 8-bit ALU result to BCD (sequential double-dabble) and scans it onto a
// multiplexed active-low 4-digit seven-segment display. Optional: `define LEADING_ZERO_BLANK_EN.
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_result_display_if.slave bus
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned ITER_W = 3;
    localparam logic [6:0]  BLANK  = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [7:0]          shreg;
    logic [11:0]         scratch;
    logic [7:0]          last_val;
    logic                first;
    logic [ITER_W-1:0]   iter;
    logic                busy;
    logic [3:0]          bcd_h, bcd_t, bcd_o;
    logic [CNT_W-1:0]    refresh_cnt;
    logic [1:0]          digit_sel;
    logic [3:0]          an;
    logic [6:0]          seg;
    logic                dp;

    logic [11:0]         adj_c;
    logic [1:0]          sel_nxt_c;
    logic [3:0]          an_nxt_c;
    logic [6:0]          seg_nxt_c;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        case (d)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = BLANK;
        endcase
    endfunction

    // Add-3 correction applied to every scratch nibble before each shift
    always_comb begin
        adj_c = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj_c[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM; bcd_* only load in DONE so partial values never escape
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            last_val <= '0;
            first    <= 1'b1;
            iter     <= '0;
            busy     <= 1'b0;
            bcd_h    <= '0;
            bcd_t    <= '0;
            bcd_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (first || (bus.result != last_val)) begin
                        shreg    <= bus.result;
                        last_val <= bus.result;
                        first    <= 1'b0;
                        scratch  <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= 12'({adj_c, shreg[7]});
                    shreg   <= {shreg[6:0], 1'b0};
                    iter    <= iter + ITER_W'(1);
                    if (iter == ITER_W'(7))
                        state <= DONE;
                end
                DONE: begin
                    bcd_h <= scratch[11:8];
                    bcd_t <= scratch[7:4];
                    bcd_o <= scratch[3:0];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next digit select and its anode/segment pattern, registered together below
    always_comb begin
        sel_nxt_c = digit_sel;
        if (refresh_cnt == CNT_W'(REFRESH_DIV - 1))
            sel_nxt_c = (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;

        an_nxt_c  = 4'b1111;
        seg_nxt_c = BLANK;
        case (sel_nxt_c)
            2'd0: begin
                an_nxt_c  = 4'b1110;
                seg_nxt_c = seg_dec(bcd_o);
            end
            2'd1: begin
                an_nxt_c  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                seg_nxt_c = (bcd_h == 4'd0 && bcd_t == 4'd0) ? BLANK : seg_dec(bcd_t);
`else
                seg_nxt_c = seg_dec(bcd_t);
`endif
            end
            2'd2: begin
                an_nxt_c  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                seg_nxt_c = (bcd_h == 4'd0) ? BLANK : seg_dec(bcd_h);
`else
                seg_nxt_c = seg_dec(bcd_h);
`endif
            end
            default: begin
                an_nxt_c  = 4'b1111;
                seg_nxt_c = BLANK;
            end
        endcase
    end

    // Scan counter and registered display drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_sel   <= '0;
            an          <= 4'b1111;
            seg         <= BLANK;
            dp          <= 1'b1;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1))
                refresh_cnt <= '0;
            else
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            digit_sel <= sel_nxt_c;
            an        <= an_nxt_c;
            seg       <= seg_nxt_c;
            dp        <= 1'b1;
        end
    end

    assign bus.busy         = busy;
    assign bus.bcd_hundreds = bcd_h;
    assign bus.bcd_tens     = bcd_t;
    assign bus.bcd_ones     = bcd_o;
    assign bus.an           = an;
    assign bus.seg          = seg;
    assign bus.dp           = dp;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: stimulus pushes expected BCD triples,
// a monitor pops and compares them whenever a conversion completes.
`timescale 1ns/1ps
module tb_alu_result_display;

    localparam int unsigned REFRESH_DIV = 4;

    logic clk;
    logic rst_n;
    alu_result_display_if bus ();

    alu_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [11:0] sb_q[$];
    logic [3:0]  eh, et, eo;
    logic        busy_prev;
    logic [11:0] bcd_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        if (idx == 0) return seg_code(eo);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 1) return (eh == 0 && et == 0) ? 7'b1111111 : seg_code(et);
        return (eh == 0) ? 7'b1111111 : seg_code(eh);
`else
        if (idx == 1) return seg_code(et);
        return seg_code(eh);
`endif
    endfunction

    // Monitor: compare bcd on each completed conversion; flag any other bcd movement
    always @(negedge rst_n) begin
        busy_prev = 1'b0;
        bcd_prev  = '0;
    end

    initial begin
        logic [11:0] cur;
        logic [11:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones};
                if (busy_prev && !bus.busy) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_unexpected: got %0h with empty queue", cur);
                    end else begin
                        exp = sb_q.pop_front();
                        check("conv_bcd", 32'(cur), 32'(exp));
                    end
                end else if (cur != bcd_prev) begin
                    n_total++;
                    $display("FAIL bcd_glitch: got %0h expected %0h", cur, bcd_prev);
                end
                busy_prev = bus.busy;
                bcd_prev  = cur;
            end
        end
    end

    task automatic wait_conv(output int n);
        int guard;
        guard = 0;
        n = 0;
        while (!bus.busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("busy_rise", 32'(bus.busy), 32'd1);
        while (bus.busy && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Follow the scan for a number of full digit periods
    task automatic scan_check(input int periods);
        logic [3:0] an_seq [3];
        logic [3:0] a0;
        int idx;
        int guard;
        an_seq = '{4'b1110, 4'b1101, 4'b1011};
        a0 = bus.an;
        guard = 0;
        while (bus.an == a0 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        idx = (bus.an == 4'b1101) ? 1 : (bus.an == 4'b1011) ? 2 : 0;
        for (int p = 0; p < periods; p++) begin
            for (int s = 0; s < REFRESH_DIV; s++) begin
                if (p != 0 || s != 0) @(negedge clk);
                check("scan_an", 32'(bus.an), 32'(an_seq[idx]));
                check("scan_seg", 32'(bus.seg), 32'(exp_seg(idx)));
            end
            idx = (idx + 1) % 3;
        end
    endtask

    initial begin
        int n;
        int rises;
        logic bp;
        rst_n = 1'b1;
        bus.result = 8'd0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_an", 32'(bus.an), 32'hf);
        check("rst_seg", 32'(bus.seg), 32'h7f);
        check("rst_dp", 32'(bus.dp), 32'd1);
        check("rst_bcd", 32'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 32'd0);

        // First conversion forced by the first flag
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb_q.push_back(12'h000);
        {eh, et, eo} = 12'h000;
        wait_conv(n);
        check("busy_len_first", 32'(n), 32'd9);
        scan_check(6);
        check("dp_held", 32'(bus.dp), 32'd1);

        // 255
        bus.result = 8'd255;
        sb_q.push_back(12'h255);
        wait_conv(n);
        check("busy_len_255", 32'(n), 32'd9);
        {eh, et, eo} = 12'h255;
        scan_check(6);

        // 100 then 42 during the 3rd busy cycle
        bus.result = 8'd100;
        sb_q.push_back(12'h100);
        sb_q.push_back(12'h042);
        n = 0;
        while (n < 3 && n < 20) begin
            @(negedge clk);
            if (bus.busy) n++;
        end
        bus.result = 8'd42;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bcd_100", 32'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 32'h100);
        @(negedge clk);
        check("busy_reassert", 32'(bus.busy), 32'd1);
        wait_conv(n);
        check("bcd_42", 32'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 32'h042);
        {eh, et, eo} = 12'h042;
        scan_check(3);

        // Reset in the 5th shift cycle of converting 200
        bus.result = 8'd200;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_an", 32'(bus.an), 32'hf);
        check("mid_rst_seg", 32'(bus.seg), 32'h7f);
        check("mid_rst_bcd", 32'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb_q.push_back(12'h200);
        wait_conv(n);
        check("busy_len_200", 32'(n), 32'd9);
        check("bcd_200", 32'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 32'h200);

        // 7: leading-zero behaviour
        bus.result = 8'd7;
        sb_q.push_back(12'h007);
        wait_conv(n);
        {eh, et, eo} = 12'h007;
        scan_check(6);

        // 63 held: exactly one conversion, continuous scan
        bus.result = 8'd63;
        sb_q.push_back(12'h063);
        rises = 0;
        bp = bus.busy;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.busy && !bp) rises++;
            bp = bus.busy;
        end
        check("one_conv_63", 32'(rises), 32'd1);
        {eh, et, eo} = 12'h063;
        scan_check(12);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
